// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Registered WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND) with a
//   single-entry output register and valid/ready handshakes on both sides.
//   The unit sustains one operation per cycle. It also counts accepted
//   transactions.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   a/b/op valid this cycle
//   in_ready   block can accept this cycle
//   a, b       WIDTH-bit operands
//   op         00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  out/out_zero hold a result
//   out_ready  consumer takes the result this cycle
//   out        registered result
//   out_zero   registered flag, result == 0
//   count      accepted inputs since reset (wraps)
module logic_unit_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 out_zero,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] res;
    logic             accept;
    logic             take;

    assign out_valid = (state == FULL);
    // A full register frees up in the same cycle that the consumer drains it.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    always_comb begin
        res = '0;
        case (op)
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = a ^ b;
            default: res = ~(a & b);
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (accept) state_nxt = FULL;
            default: begin
                if (take && !accept) state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out      <= '0;
            out_zero <= 1'b0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            // When the register drains without a refill, out/out_zero keep their last value.
            if (accept) begin
                out      <= res;
                out_zero <= (res == '0);
                count    <= count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out;
    logic        out_zero;
    logic [15:0] count;

    // second instance with a narrow counter for wrap checks
    logic        in_valid2;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out2;
    logic        out_zero2;
    logic [1:0]  count2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_zero(out_zero), .count(count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(8'h01), .b(8'h01), .op(2'b00), .out_valid(out_valid2), .out_ready(out_ready2),
        .out(out2), .out_zero(out_zero2), .count(count2)
    );

    // Reference model: a one-deep queue of pending results.
    logic [7:0] q[$];
    logic [7:0] m_last;
    logic       m_zero;
    int         m_cnt;
    bit         chk_en;

    function automatic logic [7:0] f(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge. Drives inputs, checks outputs before the edge, then advances the model.
    task automatic step(input logic r, input logic v, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [1:0] iop, input logic ordy);
        bit full;
        bit acc;
        bit tk;
        rst = r; in_valid = v; a = ia; b = ib; op = iop; out_ready = ordy;
        full = (q.size() != 0);
        acc  = v && (!full || ordy);
        tk   = full && ordy;
        #1;
        if (chk_en) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, !full || ordy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, full});
            chk("out",       {24'd0, out},       {24'd0, m_last});
            chk("out_zero",  {31'd0, out_zero},  {31'd0, m_zero});
            chk("count",     {16'd0, count},     m_cnt & 32'hFFFF);
        end
        @(posedge clk);
        if (r) begin
            q.delete(); m_last = '0; m_zero = 1'b0; m_cnt = 0;
        end else begin
            if (tk) void'(q.pop_front());
            if (acc) begin
                q.push_back(f(ia, ib, iop));
                m_last = f(ia, ib, iop);
                m_zero = (m_last == 8'h00);
                m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp_out;
        logic       exp_zero;
    } vec_t;

    vec_t tv[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        tv[0] = '{8'hF0, 8'h3C, 2'b00, 8'h30, 1'b0};
        tv[1] = '{8'hF0, 8'h3C, 2'b01, 8'hFC, 1'b0};
        tv[2] = '{8'hF0, 8'h3C, 2'b10, 8'hCC, 1'b0};
        tv[3] = '{8'hF0, 8'h3C, 2'b11, 8'hCF, 1'b0};
        tv[4] = '{8'hFF, 8'hFF, 2'b11, 8'h00, 1'b1};
        tv[5] = '{8'hFF, 8'hFF, 2'b00, 8'hFF, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; out_ready2 = 1'b1;
        q.delete(); m_last = '0; m_zero = 1'b0; m_cnt = 0; chk_en = 1'b0;
        @(negedge clk);

        // 1. reset
        step(1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        step(1'b1, 1'b1, 8'hAA, 8'h55, 2'b01, 1'b1);
        chk_en = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out",       {24'd0, out},       32'd0);
        chk("rst_out_zero",  {31'd0, out_zero},  32'd0);
        chk("rst_count",     {16'd0, count},     32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);

        // 2/3. table vectors, back-to-back
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, tv[i].a, tv[i].b, tv[i].op, 1'b1);
            chk("tbl_out",  {24'd0, out},      {24'd0, tv[i].exp_out});
            chk("tbl_zero", {31'd0, out_zero}, {31'd0, tv[i].exp_zero});
            if (i == 3) chk("tbl_count4", {16'd0, count}, 32'd4);
        end
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1);   // drain

        // 4. backpressure: one accept, then stall with changing inputs
        step(1'b0, 1'b1, 8'h0F, 8'hF5, 2'b10, 1'b1);   // result FA
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'(i * 17), 8'(i * 29), 2'(i), 1'b0);
            chk("stall_out",   {24'd0, out},      32'hFA);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
        end
        step(1'b0, 1'b1, 8'h12, 8'h34, 2'b01, 1'b1);
        chk("nogap_valid", {31'd0, out_valid}, 32'd1);
        chk("nogap_out",   {24'd0, out},       32'h36);
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_hold",  {24'd0, out},       32'h36);

        // 5. 2-bit counter wrap on the narrow instance
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1;
            @(posedge clk); #1;
            chk("cnt2", {30'd0, count2}, (i + 1) % 4);
            @(negedge clk);
        end
        in_valid2 = 1'b0;
        chk("cnt2_out", {24'd0, out2}, 32'h01);

        // 6. reset while full and stalled, then immediate accept
        step(1'b0, 1'b1, 8'hC3, 8'h0F, 2'b00, 1'b0);
        step(1'b0, 1'b1, 8'h11, 8'h22, 2'b01, 1'b0);
        step(1'b1, 1'b1, 8'h11, 8'h22, 2'b01, 1'b0);
        chk("rst6_valid", {31'd0, out_valid}, 32'd0);
        chk("rst6_count", {16'd0, count},     32'd0);
        step(1'b0, 1'b1, 8'h5A, 8'hFF, 2'b00, 1'b0);
        chk("post_rst_out",   {24'd0, out},       32'h5A);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 2'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
